// File: rtl/run_splitter_pkg.sv
// Shared tuple constants for the run splitter / merger pair.
// Holds tuple width, key field position and the run terminator key.
package run_splitter_pkg;

    localparam int DATA_WIDTH = 128;
    localparam int KEY_LSB = 0;
    localparam int KEY_MSB = 31;
    localparam logic [KEY_MSB-KEY_LSB:0] TERM_KEY = '0;

    function automatic logic is_term(
        input logic [KEY_MSB-KEY_LSB:0] key
    );
        return key == TERM_KEY;
    endfunction

endpackage

// File: rtl/run_splitter_if.sv
// Upstream write port and two downstream FWFT read ports of run_splitter.
// slave: splitter side; master: traffic source / sink side.
interface run_splitter_if #(
    parameter int DATA_WIDTH = run_splitter_pkg::DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_write;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_fifo_1;
    logic [DATA_WIDTH-1:0] o_fifo_2;
    logic                  o_fifo_1_empty;
    logic                  o_fifo_2_empty;
    logic                  i_fifo_1_read;
    logic                  i_fifo_2_read;
    logic [15:0]           o_run_count;
    logic                  o_overrun;

    modport slave (
        input  i_data, i_write, i_fifo_1_read, i_fifo_2_read,
        output o_ready, o_fifo_1, o_fifo_2,
        output o_fifo_1_empty, o_fifo_2_empty,
        output o_run_count, o_overrun
    );

    modport master (
        output i_data, i_write, i_fifo_1_read, i_fifo_2_read,
        input  o_ready, o_fifo_1, o_fifo_2,
        input  o_fifo_1_empty, o_fifo_2_empty,
        input  o_run_count, o_overrun
    );

endinterface

// File: rtl/sync_fifo16.sv
// First-word-fall-through synchronous FIFO, synchronous active-high reset.
// Ports: clk, rst, wr_en/wr_data, rd_en/rd_data (head), empty, full, count.
module sync_fifo16 #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_rd, do_wr;

    always_comb begin
        do_rd    = 1'b0;
        do_wr    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!rst) begin
            do_rd = rd_en && (count_q != '0);
            // a pop on the same edge frees the slot for a write when full
            do_wr = wr_en && ((count_q != FULL_CNT) || do_rd);
        end
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        count_d = count_q + {{AW{1'b0}}, do_wr}
                          - {{AW{1'b0}}, do_rd};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;

endmodule

// File: rtl/run_splitter.sv
// Splits a tuple stream into two FWFT buffers, one run per buffer in turn.
// Ports: i_clk, i_rst, bus (write port, two read ports, run count, overrun).
module run_splitter #(
    parameter int DATA_WIDTH = run_splitter_pkg::DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    run_splitter_if.slave  bus
);

    import run_splitter_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

    logic        sel_q, sel_d;
    logic [15:0] run_count_q, run_count_d;
    logic        overrun_q, overrun_d;
    logic        ready_q, ready_d;

    logic          wr_1, wr_2;
    logic          full_1, full_2;
    logic          empty_1, empty_2;
    logic [AW:0]   cnt_1, cnt_2;
    logic          pop_1, pop_2;
    logic          acc_1, acc_2;
    logic [AW:0]   nxt_1, nxt_2;
    logic          term;

    assign wr_1 = bus.i_write && !sel_q;
    assign wr_2 = bus.i_write &&  sel_q;

    sync_fifo16 #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (wr_1),
        .wr_data (bus.i_data),
        .rd_en   (bus.i_fifo_1_read),
        .rd_data (bus.o_fifo_1),
        .empty   (empty_1),
        .full    (full_1),
        .count   (cnt_1)
    );

    sync_fifo16 #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_2 (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (wr_2),
        .wr_data (bus.i_data),
        .rd_en   (bus.i_fifo_2_read),
        .rd_data (bus.o_fifo_2),
        .empty   (empty_2),
        .full    (full_2),
        .count   (cnt_2)
    );

    always_comb begin
        sel_d       = sel_q;
        run_count_d = run_count_q;
        overrun_d   = overrun_q;
        term        = is_term(bus.i_data[KEY_MSB:KEY_LSB]);
        pop_1       = bus.i_fifo_1_read && !empty_1;
        pop_2       = bus.i_fifo_2_read && !empty_2;
        acc_1       = wr_1 && (!full_1 || pop_1);
        acc_2       = wr_2 && (!full_2 || pop_2);
        // occupancy after this edge; ready looks ahead so two
        // in-flight writes always find room
        nxt_1 = cnt_1 + {{AW{1'b0}}, acc_1} - {{AW{1'b0}}, pop_1};
        nxt_2 = cnt_2 + {{AW{1'b0}}, acc_2} - {{AW{1'b0}}, pop_2};
        ready_d = (nxt_1 <= READY_MAX) && (nxt_2 <= READY_MAX);
        if (bus.i_write) begin
            // a dropped terminator still closes the run
            if (term) begin
                sel_d       = !sel_q;
                run_count_d = run_count_q + 16'd1;
            end
            if (!(acc_1 || acc_2)) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel_q       <= 1'b0;
            run_count_q <= '0;
            overrun_q   <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            run_count_q <= run_count_d;
            overrun_q   <= overrun_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.o_ready        = ready_q;
    assign bus.o_run_count    = run_count_q;
    assign bus.o_overrun      = overrun_q;
    assign bus.o_fifo_1_empty = empty_1;
    assign bus.o_fifo_2_empty = empty_2;

endmodule

// File: tb/tb_run_splitter.sv
// Randomized and directed bench for run_splitter against a queue-based model.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_run_splitter;

    localparam int DW    = 128;
    localparam int DEPTH = 16;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    always #5 i_clk = ~i_clk;

    run_splitter_if #(.DATA_WIDTH(DW)) bus ();

    run_splitter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    bit            sel;
    int unsigned   rc;
    bit            ovr;
    bit            rdy;
    bit            started = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] key);
        logic [DW-1:0] t;
        t = {$urandom(), $urandom(), $urandom(), key};
        return t;
    endfunction

    // Reference model: two queues, a run selector and counters.
    initial forever begin
        @(posedge i_clk);
        if (i_rst) begin
            q1.delete();
            q2.delete();
            sel = 1'b0;
            rc  = 0;
            ovr = 1'b0;
            rdy = 1'b0;
        end else begin
            if (bus.i_fifo_1_read && q1.size() > 0) void'(q1.pop_front());
            if (bus.i_fifo_2_read && q2.size() > 0) void'(q2.pop_front());
            if (bus.i_write) begin
                if (!sel) begin
                    if (q1.size() < DEPTH) q1.push_back(bus.i_data);
                    else ovr = 1'b1;
                end else begin
                    if (q2.size() < DEPTH) q2.push_back(bus.i_data);
                    else ovr = 1'b1;
                end
                if (bus.i_data[31:0] == 32'd0) begin
                    sel = !sel;
                    rc  = (rc + 1) % 65536;
                end
            end
            rdy = (DEPTH - q1.size() >= 2) && (DEPTH - q2.size() >= 2);
        end
        started = 1'b1;
    end

    always @(negedge i_clk) begin
        if (started) begin
            chk("empty1", bus.o_fifo_1_empty, q1.size() == 0);
            chk("empty2", bus.o_fifo_2_empty, q2.size() == 0);
            if (q1.size() > 0) chk("head1", bus.o_fifo_1, q1[0]);
            if (q2.size() > 0) chk("head2", bus.o_fifo_2, q2[0]);
            chk("ready", bus.o_ready, rdy);
            chk("run_count", bus.o_run_count, rc[15:0]);
            chk("overrun", bus.o_overrun, ovr);
        end
    end

    task automatic cyc(input bit w, input logic [DW-1:0] d,
                       input bit r1, input bit r2);
        bus.i_write       = w;
        bus.i_data        = d;
        bus.i_fifo_1_read = r1;
        bus.i_fifo_2_read = r2;
        @(negedge i_clk);
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        idle();
        i_rst = 1'b0;
        idle();
    endtask

    initial begin
        int keys_a[5];
        int n;
        bit rdy_seen;
        int rd_pct;
        logic [DW-1:0] d;

        bus.i_write       = 1'b0;
        bus.i_data        = '0;
        bus.i_fifo_1_read = 1'b0;
        bus.i_fifo_2_read = 1'b0;

        idle();
        idle();
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_count", bus.o_run_count, 0);
        chk("rst_empty1", bus.o_fifo_1_empty, 1);
        chk("rst_empty2", bus.o_fifo_2_empty, 1);
        i_rst = 1'b0;
        idle();
        chk("rst_release_ready", bus.o_ready, 1);

        // runs 5,9,0 | 3,0
        keys_a = '{5, 9, 0, 3, 0};
        foreach (keys_a[i]) cyc(1'b1, mk(keys_a[i]), 1'b0, 1'b0);
        chk("runs_count", bus.o_run_count, 2);
        chk("runs_head1", bus.o_fifo_1[31:0], 5);
        chk("runs_head2", bus.o_fifo_2[31:0], 3);
        chk("runs_model_q1", q1.size(), 3);
        chk("runs_model_sel", sel, 0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("runs_pop1", bus.o_fifo_1[31:0], 9);
        chk("runs_pop2", bus.o_fifo_2[31:0], 0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("runs_pop1b", bus.o_fifo_1[31:0], 0);
        chk("runs_empty2", bus.o_fifo_2_empty, 1);

        // fill buffer 1, then force one more write
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, mk(7), 1'b0, 1'b0);
            if (i == 14) chk("fill_ready14", bus.o_ready, 1);
            if (i == 15) chk("fill_ready15", bus.o_ready, 0);
        end
        cyc(1'b1, mk(7), 1'b0, 1'b0);
        chk("fill_overrun", bus.o_overrun, 1);
        chk("fill_model_q1", q1.size(), 16);

        // full buffer, write and read on the same edge
        do_reset();
        for (int i = 1; i <= 16; i++) cyc(1'b1, mk(i), 1'b0, 1'b0);
        cyc(1'b1, mk(100), 1'b1, 1'b0);
        chk("fullrw_overrun", bus.o_overrun, 0);
        chk("fullrw_head", bus.o_fifo_1[31:0], 2);
        n = 0;
        while (!bus.o_fifo_1_empty && n < 40) begin
            if (n == 15) chk("fullrw_tail", bus.o_fifo_1[31:0], 100);
            cyc(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("fullrw_occupancy", n, 16);

        // empty buffer 2, write and read on the same edge
        do_reset();
        cyc(1'b1, mk(0), 1'b0, 1'b0);
        d = mk(42);
        cyc(1'b1, d, 1'b0, 1'b1);
        chk("emptyrw_empty2", bus.o_fifo_2_empty, 0);
        chk("emptyrw_head2", bus.o_fifo_2, d);

        // reset mid-run
        do_reset();
        cyc(1'b1, mk(11), 1'b0, 1'b0);
        cyc(1'b1, mk(0), 1'b0, 1'b0);
        cyc(1'b1, mk(13), 1'b0, 1'b0);
        i_rst = 1'b1;
        cyc(1'b1, mk(14), 1'b1, 1'b1);
        i_rst = 1'b0;
        chk("midrst_empty1", bus.o_fifo_1_empty, 1);
        chk("midrst_empty2", bus.o_fifo_2_empty, 1);
        chk("midrst_count", bus.o_run_count, 0);
        chk("midrst_ready0", bus.o_ready, 0);
        idle();
        chk("midrst_ready1", bus.o_ready, 1);
        cyc(1'b1, mk(21), 1'b0, 1'b0);
        chk("midrst_lands1", bus.o_fifo_1_empty, 0);
        chk("midrst_not2", bus.o_fifo_2_empty, 1);

        // random traffic, mostly respecting o_ready
        do_reset();
        rdy_seen = bus.o_ready;
        for (int i = 0; i < 4000; i++) begin
            rd_pct = ((i / 500) % 2 == 0) ? 15 : 60;
            i_rst = ($urandom_range(499) == 0);
            cyc((rdy_seen && $urandom_range(3) != 0)
                    || $urandom_range(63) == 0,
                mk(($urandom_range(3) == 0) ? 32'd0 : $urandom()),
                $urandom_range(99) < rd_pct,
                $urandom_range(99) < rd_pct);
            rdy_seen = bus.o_ready;
        end
        i_rst = 1'b0;

        // run counter wrap
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            cyc(1'b1, mk(0), 1'b1, 1'b1);
            if (i == 65534) chk("wrap_ffff", bus.o_run_count, 16'hFFFF);
        end
        chk("wrap_zero", bus.o_run_count, 0);

        idle();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
